// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter that shares one RAM read/write port between two requesters.
// The RAM command is registered; a tag pipeline routes read data back to the issuer.
module ram_port_arbiter #(
  parameter int DATASIZE  = 18,
  parameter int ADDRSIZE  = 8,
  parameter int PIPELINED = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic                req0_write,
  input  logic [ADDRSIZE-1:0] req0_addr,
  input  logic [DATASIZE-1:0] req0_wdata,
  output logic                req0_rvalid,
  output logic [DATASIZE-1:0] req0_rdata,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic                req1_write,
  input  logic [ADDRSIZE-1:0] req1_addr,
  input  logic [DATASIZE-1:0] req1_wdata,
  output logic                req1_rvalid,
  output logic [DATASIZE-1:0] req1_rdata,
  output logic                ram_wen,
  output logic                ram_ren,
  output logic [ADDRSIZE-1:0] ram_addr,
  output logic [DATASIZE-1:0] ram_wdata,
  input  logic [DATASIZE-1:0] ram_rdata,
  output logic                busy
);
  localparam int TAGDEPTH = 1 + PIPELINED;

  logic                ptr_q, ptr_d;
  logic                grant0, grant1, accept, sel_write;
  logic [ADDRSIZE-1:0] sel_addr;
  logic [DATASIZE-1:0] sel_wdata;
  logic                ram_wen_q, ram_wen_d;
  logic                ram_ren_q, ram_ren_d;
  logic [ADDRSIZE-1:0] ram_addr_q, ram_addr_d;
  logic [DATASIZE-1:0] ram_wdata_q, ram_wdata_d;
  logic [TAGDEPTH-1:0] tag_v_q, tag_v_d;
  logic [TAGDEPTH-1:0] tag_id_q, tag_id_d;
  logic                rvalid0_q, rvalid0_d;
  logic                rvalid1_q, rvalid1_d;

  // ptr_q = 0 favours requester 0 when both are valid; nothing is granted during reset
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (req0_valid && (!req1_valid || !ptr_q)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign accept    = grant0 | grant1;
  assign sel_write = grant1 ? req1_write : req0_write;
  assign sel_addr  = grant1 ? req1_addr  : req0_addr;
  assign sel_wdata = grant1 ? req1_wdata : req0_wdata;

  always_comb begin
    ptr_d       = accept ? grant0 : ptr_q;
    ram_wen_d   = accept & sel_write;
    ram_ren_d   = accept & ~sel_write;
    ram_addr_d  = accept ? sel_addr  : ram_addr_q;
    ram_wdata_d = accept ? sel_wdata : ram_wdata_q;
    tag_v_d     = tag_v_q;
    tag_id_d    = tag_id_q;
    tag_v_d[0]  = ram_ren_d;
    tag_id_d[0] = grant1;
    for (int i = 1; i < TAGDEPTH; i++) begin
      tag_v_d[i]  = tag_v_q[i-1];
      tag_id_d[i] = tag_id_q[i-1];
    end
    rvalid0_d = tag_v_q[TAGDEPTH-1] & ~tag_id_q[TAGDEPTH-1];
    rvalid1_d = tag_v_q[TAGDEPTH-1] &  tag_id_q[TAGDEPTH-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= 1'b0;
      ram_wen_q   <= 1'b0;
      ram_ren_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      tag_v_q     <= '0;
      tag_id_q    <= '0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      ram_wen_q   <= ram_wen_d;
      ram_ren_q   <= ram_ren_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      tag_v_q     <= tag_v_d;
      tag_id_q    <= tag_id_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
    end
  end

  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign ram_wen     = ram_wen_q;
  assign ram_ren     = ram_ren_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign req0_rvalid = rvalid0_q;
  assign req1_rvalid = rvalid1_q;
  assign req0_rdata  = ram_rdata;
  assign req1_rdata  = ram_rdata;
  // The return cycle still counts as in flight
  assign busy        = (|tag_v_q) | rvalid0_q | rvalid1_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: one PIPELINED=0 and one PIPELINED=1 instance share stimulus;
// a spec-level model feeds scoreboard queues that an independent monitor drains.
module tb_ram_port_arbiter;
  typedef struct packed {
    bit          idle;
    bit          drop;
    bit          wr;
    logic [7:0]  addr;
    logic [17:0] data;
  } cmd_t;
  typedef struct {
    int          e0;
    int          inst;
    bit          id;
    logic [17:0] data;
  } rd_t;
  typedef struct {
    int          due;
    bit          wr;
    logic [7:0]  addr;
    logic [17:0] data;
  } ex_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  int   acc_total = 0;

  logic        drv_v[2], drv_w[2];
  logic [7:0]  drv_a[2];
  logic [17:0] drv_d[2];

  logic        rdy0[2], rdy1[2], rv0[2], rv1[2], wen[2], ren[2], bsy[2];
  logic [7:0]  raddr[2];
  logic [17:0] wdat[2], rram[2], rd0[2], rd1[2];

  logic [17:0] mem[2][256];
  logic [17:0] rd1q[2], rd2q[2];
  logic        ren_d[2];
  logic [17:0] model_mem[256];

  bit   m_ptr = 1'b0;
  bit   acc_seen[2];
  rd_t  sbq[$];
  ex_t  cq[$];
  cmd_t stq0[$], stq1[$];
  cmd_t cur[2];
  bit   cur_act[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_port_arbiter #(.DATASIZE(18), .ADDRSIZE(8), .PIPELINED(0)) u_p0 (
    .clk(clk), .rst(rst),
    .req0_valid(drv_v[0]), .req0_ready(rdy0[0]), .req0_write(drv_w[0]), .req0_addr(drv_a[0]),
    .req0_wdata(drv_d[0]), .req0_rvalid(rv0[0]), .req0_rdata(rd0[0]),
    .req1_valid(drv_v[1]), .req1_ready(rdy1[0]), .req1_write(drv_w[1]), .req1_addr(drv_a[1]),
    .req1_wdata(drv_d[1]), .req1_rvalid(rv1[0]), .req1_rdata(rd1[0]),
    .ram_wen(wen[0]), .ram_ren(ren[0]), .ram_addr(raddr[0]), .ram_wdata(wdat[0]),
    .ram_rdata(rram[0]), .busy(bsy[0]));

  ram_port_arbiter #(.DATASIZE(18), .ADDRSIZE(8), .PIPELINED(1)) u_p1 (
    .clk(clk), .rst(rst),
    .req0_valid(drv_v[0]), .req0_ready(rdy0[1]), .req0_write(drv_w[0]), .req0_addr(drv_a[0]),
    .req0_wdata(drv_d[0]), .req0_rvalid(rv0[1]), .req0_rdata(rd0[1]),
    .req1_valid(drv_v[1]), .req1_ready(rdy1[1]), .req1_write(drv_w[1]), .req1_addr(drv_a[1]),
    .req1_wdata(drv_d[1]), .req1_rvalid(rv1[1]), .req1_rdata(rd1[1]),
    .ram_wen(wen[1]), .ram_ren(ren[1]), .ram_addr(raddr[1]), .ram_wdata(wdat[1]),
    .ram_rdata(rram[1]), .busy(bsy[1]));

  // RAM models: latency 1, and latency 2 with output register gated by delayed read enable
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (wen[k]) mem[k][raddr[k]] <= wdat[k];
      if (ren[k]) rd1q[k] <= mem[k][raddr[k]];
      ren_d[k] <= ren[k];
      if (ren_d[k]) rd2q[k] <= rd1q[k];
    end
  end
  assign rram[0] = rd1q[0];
  assign rram[1] = rd2q[1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  // Reference model: arbitration rule, acceptance, memory contents and expected responses
  always @(negedge clk) begin
    bit   win;
    bit   any;
    rd_t  r;
    ex_t  e;
    acc_seen[0] = 1'b0;
    acc_seen[1] = 1'b0;
    if (!rst) begin
      any = drv_v[0] | drv_v[1];
      win = !drv_v[0] ? 1'b1 : (!drv_v[1] ? 1'b0 : m_ptr);
      for (int k = 0; k < 2; k++) begin
        chk("req0_ready", 32'(rdy0[k]), 32'(any && !win));
        chk("req1_ready", 32'(rdy1[k]), 32'(any && win));
      end
      if (any) begin
        acc_seen[win] = 1'b1;
        acc_total++;
        m_ptr = !win;
        e.due = cyc + 1; e.wr = drv_w[win]; e.addr = drv_a[win]; e.data = drv_d[win];
        cq.push_back(e);
        if (drv_w[win]) model_mem[drv_a[win]] = drv_d[win];
        else begin
          for (int k = 0; k < 2; k++) begin
            r.e0 = cyc; r.inst = k; r.id = win; r.data = model_mem[drv_a[win]];
            sbq.push_back(r);
          end
        end
      end
    end
  end

  // Monitor: compares DUT outputs against whatever the model has queued
  always @(negedge clk) begin
    ex_t        e;
    bit         hit;
    int         idx;
    int         lat;
    bit         eb;
    logic [1:0] erv;
    #1;
    if (!rst) begin
      hit = (cq.size() > 0) && (cq[0].due == cyc);
      if (hit) e = cq[0];
      for (int k = 0; k < 2; k++) begin
        if (hit) begin
          chk("ram_wen", 32'(wen[k]), 32'(e.wr));
          chk("ram_ren", 32'(ren[k]), 32'(!e.wr));
          chk("ram_addr", 32'(raddr[k]), 32'(e.addr));
          if (e.wr) chk("ram_wdata", 32'(wdat[k]), 32'(e.data));
        end else begin
          chk("ram_idle", 32'({wen[k], ren[k]}), 32'(0));
        end
      end
      if (hit) void'(cq.pop_front());
      for (int k = 0; k < 2; k++) begin
        lat = (k == 0) ? 2 : 3;
        eb = 1'b0;
        idx = -1;
        foreach (sbq[i]) begin
          if (sbq[i].inst == k) begin
            if (sbq[i].e0 + 1 <= cyc && cyc <= sbq[i].e0 + lat) eb = 1'b1;
            if (idx < 0) idx = i;
          end
        end
        chk("busy", 32'(bsy[k]), 32'(eb));
        erv = 2'b00;
        if (idx >= 0 && sbq[idx].e0 + lat == cyc) begin
          erv = sbq[idx].id ? 2'b01 : 2'b10;
          if (sbq[idx].id) chk("req1_rdata", 32'(rd1[k]), 32'(sbq[idx].data));
          else             chk("req0_rdata", 32'(rd0[k]), 32'(sbq[idx].data));
          sbq.delete(idx);
        end
        chk("rvalid", 32'({rv0[k], rv1[k]}), 32'(erv));
      end
    end
  end

  task automatic step();
    cmd_t nx;
    @(posedge clk);
    #2;
    for (int r = 0; r < 2; r++) begin
      if (cur_act[r] && (acc_seen[r] || cur[r].drop)) cur_act[r] = 1'b0;
      if (!cur_act[r]) begin
        if (r == 0 && stq0.size() > 0) begin
          nx = stq0.pop_front(); cur[r] = nx; cur_act[r] = !nx.idle;
        end else if (r == 1 && stq1.size() > 0) begin
          nx = stq1.pop_front(); cur[r] = nx; cur_act[r] = !nx.idle;
        end
      end
      drv_v[r] = cur_act[r];
      drv_w[r] = cur[r].wr;
      drv_a[r] = cur[r].addr;
      drv_d[r] = cur[r].data;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((stq0.size() > 0 || stq1.size() > 0 || cur_act[0] || cur_act[1]) && n < 2000) begin
      step();
      n++;
    end
    if (n >= 2000) begin
      total++;
      $display("FAIL drain_timeout: got %0d cycles required < 2000", n);
    end
    repeat (6) step();
  endtask

  function automatic cmd_t mk(bit wr, logic [7:0] addr, logic [17:0] data);
    cmd_t c;
    c.idle = 1'b0; c.drop = 1'b0; c.wr = wr; c.addr = addr; c.data = data;
    return c;
  endfunction

  task automatic chk_zero();
    for (int k = 0; k < 2; k++)
      chk("reset_outputs", 32'({rdy0[k], rdy1[k], rv0[k], rv1[k], wen[k], ren[k], raddr[k], bsy[k]}), 32'(0));
    for (int k = 0; k < 2; k++) chk("reset_wdata", 32'(wdat[k]), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_t c;
    int   n0;
    int   n;
    for (int i = 0; i < 256; i++) begin
      model_mem[i] = 18'($urandom);
      mem[0][i] = model_mem[i];
      mem[1][i] = model_mem[i];
    end
    model_mem[8'h10] = 18'h2A55;
    mem[0][8'h10] = 18'h2A55;
    mem[1][8'h10] = 18'h2A55;
    for (int r = 0; r < 2; r++) begin
      drv_v[r] = 1'b0; drv_w[r] = 1'b0; drv_a[r] = '0; drv_d[r] = '0;
      cur[r] = mk(1'b0, 8'h0, 18'h0); cur_act[r] = 1'b0;
    end
    #1;
    chk_zero();
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // single read
    stq0.push_back(mk(1'b0, 8'h10, 18'h0));
    drain();

    // contention: writes from req0, reads from req1
    for (int i = 0; i < 4; i++) begin
      stq0.push_back(mk(1'b1, 8'(i), 18'(i + 1)));
      stq1.push_back(mk(1'b0, 8'(i + 4), 18'h0));
    end
    n0 = acc_total;
    step();
    repeat (8) step();
    chk("contention_accepts", 32'(acc_total - n0), 32'(8));
    drain();

    // write then read same address, same requester
    stq1.push_back(mk(1'b1, 8'hFF, 18'h3FFFF));
    stq1.push_back(mk(1'b0, 8'hFF, 18'h0));
    drain();

    // back-to-back reads
    for (int i = 1; i <= 3; i++) stq0.push_back(mk(1'b0, 8'(i), 18'h0));
    drain();

    // idle and drop: req1 holds the grant by pointer while req0 pulses and drops
    c = mk(1'b0, 8'h40, 18'h0); c.drop = 1'b1;
    stq0.push_back(c);
    stq1.push_back(mk(1'b0, 8'h41, 18'h0));
    drain();
    stq0.push_back(mk(1'b0, 8'h42, 18'h0));
    stq1.push_back(mk(1'b0, 8'h43, 18'h0));
    drain();

    // reset one cycle after a read accept
    stq0.push_back(mk(1'b0, 8'h20, 18'h0));
    n = 0;
    step();
    while (!acc_seen[0] && n < 50) begin
      step();
      n++;
    end
    rst = 1'b1;
    cur[0] = mk(1'b0, 8'h30, 18'h0); cur_act[0] = 1'b1;
    cur[1] = mk(1'b0, 8'h31, 18'h0); cur_act[1] = 1'b1;
    for (int r = 0; r < 2; r++) begin
      drv_v[r] = 1'b1; drv_w[r] = 1'b0; drv_a[r] = cur[r].addr; drv_d[r] = cur[r].data;
    end
    #1;
    chk_zero();
    sbq.delete();
    cq.delete();
    m_ptr = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    drain();

    // randomized traffic with idles and drops
    for (int j = 0; j < 150; j++) begin
      for (int r = 0; r < 2; r++) begin
        n = $urandom_range(0, 9);
        c = mk(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 18'($urandom));
        c.idle = (n < 3);
        c.drop = (n == 3);
        if (r == 0) stq0.push_back(c);
        else stq1.push_back(c);
      end
    end
    drain();

    repeat (6) step();
    chk("scoreboard_empty", 32'(sbq.size()), 32'(0));
    chk("command_queue_empty", 32'(cq.size()), 32'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
